// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: two-requester operand/handshake bundle for the shared logic unit
interface logic_unit_arbiter_if #(parameter int WIDTH = 16);
    logic             req0;
    logic [1:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [1:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    logic             zero;
    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        output gnt0, gnt1, busy, done, done_id, result, zero
    );
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        input  gnt0, gnt1, busy, done, done_id, result, zero
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one bitwise NOT/AND/OR/XOR unit between two requesters
module logic_unit_arbiter #(parameter int WIDTH = 16) (
    input logic             clk,
    input logic             rst,
    logic_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10} state_t;
    logic [1:0]       state;
    state_t           nx;
    logic             last;
    logic             owner;
    logic             win;
    logic             any_req;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    assign any_req  = bus.req0 | bus.req1;
    assign win      = bus.req1 & (~bus.req0 | ~last);
    assign res      = op_q == 2'b00 ? ~a_q : op_q == 2'b01 ? a_q & b_q : op_q == 2'b10 ? a_q | b_q : a_q ^ b_q;
    assign bus.busy = state != IDLE;
    // next state; the unused encoding falls back to IDLE
    always_comb begin
        nx = state == IDLE && any_req ? EXEC : state == EXEC ? DONE : IDLE;
    end
    // state, operand capture, grant/done pulses and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.result  <= '0;
            bus.zero    <= 1'b0;
        end else begin
            state       <= nx;
            bus.gnt0    <= state == IDLE && any_req && !win;
            bus.gnt1    <= state == IDLE && win;
            bus.done    <= state == EXEC;
            bus.done_id <= state == EXEC ? owner : state == 2'b11 ? 1'b0 : bus.done_id;
            if (state == IDLE && any_req) begin
                owner <= win;
                op_q  <= win ? bus.op1 : bus.op0;
                a_q   <= win ? bus.a1 : bus.a0;
                b_q   <= win ? bus.b1 : bus.b0;
            end
            if (state == EXEC) begin
                bus.result <= res;
                bus.zero   <= res == '0;
            end
            if (state == DONE)
                last <= owner;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed table, corner sequences and randomized model check
module tb_logic_unit_arbiter;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic_unit_arbiter_if #(.WIDTH(W)) bus();
    logic_unit_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic         r0;
        logic [1:0]   o0;
        logic [W-1:0] x0;
        logic [W-1:0] y0;
        logic         r1;
        logic [1:0]   o1;
        logic [W-1:0] x1;
        logic [W-1:0] y1;
        logic [W-1:0] res;
        logic         z;
        logic         id;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0: return ~a;
            2'd1: return a & b;
            2'd2: return a | b;
            default: return a ^ b;
        endcase
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle_in;
        bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        idle_in();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        logic         m_last, m_id, m_zero, pend0, pend1;
        logic         s_r0, s_r1;
        logic [1:0]   s_o0, s_o1;
        logic [W-1:0] s_a0, s_b0, s_a1, s_b1, m_res, m_result;
        int           m_age;
        tbl[0] = '{1'b1, 2'd0, 16'h00FF, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'hFF00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 2'd1, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 2'd2, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 2'd1, 16'hFFFF, 16'h1234, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 2'd2, 16'h0000, 16'h0000, 1'b1, 2'd3, 16'h5555, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 2'd3, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b1};
        rst = 1'b1;
        idle_in();
        tick();
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.req0 = tbl[i].r0; bus.op0 = tbl[i].o0; bus.a0 = tbl[i].x0; bus.b0 = tbl[i].y0;
            bus.req1 = tbl[i].r1; bus.op1 = tbl[i].o1; bus.a1 = tbl[i].x1; bus.b1 = tbl[i].y1;
            tick();
            chk("tbl_gnt0", bus.gnt0, !tbl[i].id);
            chk("tbl_gnt1", bus.gnt1, tbl[i].id);
            chk("tbl_busy", bus.busy, 1);
            idle_in();
            tick();
            chk("tbl_done", bus.done, 1);
            chk("tbl_done_id", bus.done_id, tbl[i].id);
            chk("tbl_result", bus.result, tbl[i].res);
            chk("tbl_zero", bus.zero, tbl[i].z);
            tick();
            chk("tbl_idle_busy", bus.busy, 0);
            chk("tbl_idle_done", bus.done, 0);
        end
        do_reset();
        bus.req0 = 1'b1; bus.op0 = 2'd2; bus.a0 = 16'h1200; bus.b0 = 16'h0034;
        bus.req1 = 1'b1; bus.op1 = 2'd3; bus.a1 = 16'hAAAA; bus.b1 = 16'hAAAA;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("alt_done", bus.done, c % 3 == 2);
            if (c % 3 == 2) begin
                chk("alt_done_id", bus.done_id, ((c - 2) / 3) % 2);
                chk("alt_result", bus.result, ((c - 2) / 3) % 2 ? 16'h0000 : 16'h1234);
            end
        end
        idle_in();
        repeat (3) tick();
        bus.req0 = 1'b1; bus.op0 = 2'd0; bus.a0 = 16'h00FF;
        tick();
        chk("hold_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0; bus.a0 = 16'hFFFF;
        tick();
        chk("hold_done", bus.done, 1);
        chk("hold_result", bus.result, 16'hFF00);
        tick();
        bus.req0 = 1'b1; bus.op0 = 2'd1; bus.a0 = 16'hFFFF; bus.b0 = 16'h0F0F;
        tick();
        chk("arst_pre_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt0", bus.gnt0, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_zero", bus.zero, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("arst_no_done", bus.done, 0);
        end
        bus.req0 = 1'b1;
        tick();
        chk("arst_next_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        tick();
        chk("arst_next_done", bus.done, 1);
        chk("arst_next_result", bus.result, 16'h0F0F);
        tick();
        bus.req1 = 1'b1; bus.op1 = 2'd3; bus.a1 = 16'h0001; bus.b1 = 16'h0000;
        tick();
        bus.req1 = 1'b0;
        tick();
        chk("ill_pre_done_id", bus.done_id, 1);
        tick();
        bus.req0 = 1'b1; bus.op0 = 2'd0; bus.a0 = 16'h0000;
        tick();
        bus.req0 = 1'b0;
        @(negedge clk);
        dut.state = 2'b11;
        @(posedge clk);
        #1;
        chk("ill_state", dut.state, 0);
        chk("ill_gnt0", bus.gnt0, 0);
        chk("ill_gnt1", bus.gnt1, 0);
        chk("ill_done", bus.done, 0);
        chk("ill_done_id", bus.done_id, 0);
        chk("ill_result_held", bus.result, 16'h0001);
        tick();
        do_reset();
        m_last = 1'b1; m_id = 1'b0; m_age = -1; m_res = '0; m_result = '0; m_zero = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            s_r0 = bus.req0; s_o0 = bus.op0; s_a0 = bus.a0; s_b0 = bus.b0;
            s_r1 = bus.req1; s_o1 = bus.op1; s_a1 = bus.a1; s_b1 = bus.b1;
            tick();
            if (m_age == 1) begin
                m_last = m_id;
                m_age  = -1;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (s_r0 || s_r1) begin
                if (s_r0 && s_r1)
                    m_id = !m_last;
                else
                    m_id = s_r1;
                m_res = m_id ? ref_op(s_o1, s_a1, s_b1) : ref_op(s_o0, s_a0, s_b0);
                m_age = 0;
            end
            if (m_age == 1) begin
                m_result = m_res;
                m_zero   = m_res == '0;
            end
            chk("rnd_gnt0", bus.gnt0, m_age == 0 && !m_id);
            chk("rnd_gnt1", bus.gnt1, m_age == 0 && m_id);
            chk("rnd_busy", bus.busy, m_age >= 0);
            chk("rnd_done", bus.done, m_age == 1);
            chk("rnd_result", bus.result, m_result);
            chk("rnd_zero", bus.zero, m_zero);
            if (m_age == 1)
                chk("rnd_done_id", bus.done_id, m_id);
            if (bus.gnt0)
                pend0 = 1'b0;
            if (bus.gnt1)
                pend1 = 1'b0;
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1'b1;
                bus.op0 = 2'($urandom);
                bus.a0  = W'($urandom);
                bus.b0  = $urandom_range(0, 7) == 0 ? ~bus.a0 : W'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1'b1;
                bus.op1 = 2'($urandom);
                bus.a1  = W'($urandom);
                bus.b1  = $urandom_range(0, 7) == 0 ? bus.a1 : W'($urandom);
            end
            bus.req0 = pend0;
            bus.req1 = pend1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
